// File: rtl/tff_seq_pkg.sv
// Shared definitions for the toggle-flop count sequencer: FSM state codes and
// count-direction constants.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_stage.sv
// Single T flip-flop counter stage on the shared system clock, async reset to 0.
module tff_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= 1'b0;
        else if (t)
            r_q <= ~r_q;
    end

    assign q = r_q;

endmodule

// File: rtl/tff_count_sequencer.sv
// Start/stop/pause sequencer driving a bank of T flip-flop stages as an
// up/down counter with terminal-count detection and optional auto-reload.
module tff_count_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           r_state;
    logic             r_dir;
    logic             r_reload;
    logic [WIDTH-1:0] r_limit;
    logic             r_done;
    logic             r_busy;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_reload_val;
    logic             w_at_term;

    assign w_term       = (r_dir == DIR_DOWN) ? '0 : r_limit;
    assign w_reload_val = (r_dir == DIR_DOWN) ? r_limit : '0;
    assign w_at_term    = (w_count == w_term);

    // Toggle mask for one step: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_step[i] = carry;
            carry     = carry & ((r_dir == DIR_DOWN) ? ~w_count[i] : w_count[i]);
        end
    end

    // Target counter value; loads are realised by toggling exactly the differing bits.
    always_comb begin
        w_next = w_count;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (stop)
                    w_next = '0;
                else if (start)
                    w_next = (dir == DIR_DOWN) ? limit : '0;
            end
            ST_RUN: begin
                if (stop)
                    w_next = '0;
                else if (w_at_term) begin
                    if (r_reload)
                        w_next = w_reload_val;
                end else if (!pause)
                    w_next = w_count ^ w_step;
            end
            ST_PAUSE: begin
                if (stop)
                    w_next = '0;
            end
            default: w_next = w_count;
        endcase
    end

    assign w_t = w_count ^ w_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        tff_stage u_stage (
            .clk (clk),
            .rst (rst),
            .t   (w_t[i]),
            .q   (w_count[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_dir    <= 1'b0;
            r_reload <= 1'b0;
            r_limit  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (start) begin
                        r_dir    <= dir;
                        r_limit  <= limit;
                        r_reload <= auto_reload;
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_at_term) begin
                        r_done <= 1'b1;
                        if (!r_reload) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end
                    end else if (pause) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count = w_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: a behavioural reference model feeds
// a scoreboard queue each cycle, plus fixed-value checks at key points.
module tb_tff_count_sequencer;

    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] count;
        logic [1:0]   state;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         pause;
    logic         dir;
    logic         auto_reload;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    int   checks;
    int   failures;
    exp_t sb[$];

    int   m_state;
    int   m_count;
    int   m_limit;
    bit   m_dir;
    bit   m_ar;
    bit   m_done;

    tff_count_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .dir         (dir),
        .auto_reload (auto_reload),
        .limit       (limit),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_count = 0;
        m_limit = 0;
        m_dir   = 1'b0;
        m_ar    = 1'b0;
        m_done  = 1'b0;
    endtask

    // Cycle-level reference: what the block should show after the coming edge.
    task automatic modelStep();
        int term;
        int reloadv;
        if (rst) begin
            modelReset();
            return;
        end
        m_done  = 1'b0;
        term    = m_dir ? 0 : m_limit;
        reloadv = m_dir ? m_limit : 0;
        case (m_state)
            0, 3: begin
                if (stop) begin
                    m_state = 0;
                    m_count = 0;
                end else if (start) begin
                    m_dir   = dir;
                    m_limit = int'(limit);
                    m_ar    = auto_reload;
                    m_state = 1;
                    m_count = dir ? int'(limit) : 0;
                end
            end
            1: begin
                if (stop) begin
                    m_state = 0;
                    m_count = 0;
                end else if (m_count == term) begin
                    m_done = 1'b1;
                    if (m_ar) m_count = reloadv;
                    else      m_state = 3;
                end else if (pause) begin
                    m_state = 2;
                end else begin
                    m_count = m_dir ? m_count - 1 : m_count + 1;
                end
            end
            default: begin
                if (stop) begin
                    m_state = 0;
                    m_count = 0;
                end else if (!pause) begin
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input string tag);
        exp_t e;
        modelStep();
        e.count = W'(m_count);
        e.state = 2'(m_state);
        e.busy  = (m_state == 1) || (m_state == 2);
        e.done  = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, ".count"}, 32'(count), 32'(e.count));
        checkOutput({tag, ".state"}, 32'(state), 32'(e.state));
        checkOutput({tag, ".busy"},  32'(busy),  32'(e.busy));
        checkOutput({tag, ".done"},  32'(done),  32'(e.done));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        dir         = 1'b0;
        auto_reload = 1'b0;
        limit       = '0;
        modelReset();

        #1;
        checkOutput("reset.count", 32'(count), 32'd0);
        checkOutput("reset.state", 32'(state), 32'd0);
        checkOutput("reset.busy",  32'(busy),  32'd0);
        checkOutput("reset.done",  32'(done),  32'd0);
        applyStimulus("rst_hold");
        applyStimulus("rst_hold");
        rst = 1'b0;
        applyStimulus("idle");
        applyStimulus("idle");

        // Up count to 5 with a start pulse injected mid-run that must be ignored
        dir = 1'b0; limit = 3'd5; auto_reload = 1'b0; start = 1'b1;
        applyStimulus("up_start");
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            start = (i == 3);
            dir   = (i == 3);
            limit = (i == 3) ? 3'd1 : 3'd5;
            applyStimulus("up_run");
        end
        start = 1'b0; dir = 1'b0; limit = 3'd5;
        checkOutput("up_at_limit", 32'(count), 32'd5);
        applyStimulus("up_term");
        checkOutput("up_done_pulse", 32'(done), 32'd1);
        checkOutput("up_done_state", 32'(state), 32'd3);
        applyStimulus("up_hold");
        checkOutput("up_hold_count", 32'(count), 32'd5);
        checkOutput("up_done_once", 32'(done), 32'd0);
        pause = 1'b1;
        applyStimulus("done_pause_ignored");
        applyStimulus("done_pause_ignored");
        pause = 1'b0;

        // Down count with auto-reload from 3
        dir = 1'b1; limit = 3'd3; auto_reload = 1'b1; start = 1'b1;
        applyStimulus("down_start");
        start = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus("down_run");
        checkOutput("down_wrapped_count", 32'(count), 32'd1);
        stop = 1'b1;
        applyStimulus("down_stop");
        stop = 1'b0;

        // Pause at count 2 for three cycles, then abort at 4 with start also high
        dir = 1'b0; limit = 3'd5; auto_reload = 1'b0; start = 1'b1;
        applyStimulus("pause_start");
        start = 1'b0;
        applyStimulus("pause_run");
        applyStimulus("pause_run");
        checkOutput("pause_at2", 32'(count), 32'd2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("paused");
        checkOutput("paused_state", 32'(state), 32'd2);
        pause = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("resume");
        checkOutput("resume_at4", 32'(count), 32'd4);
        stop = 1'b1; start = 1'b1;
        applyStimulus("abort");
        checkOutput("abort_count", 32'(count), 32'd0);
        checkOutput("abort_state", 32'(state), 32'd0);
        checkOutput("abort_no_done", 32'(done), 32'd0);
        stop = 1'b0; start = 1'b0;
        applyStimulus("after_abort");

        // limit 0: one RUN cycle at 0, then done
        dir = 1'b0; limit = 3'd0; auto_reload = 1'b0; start = 1'b1;
        applyStimulus("lim0_start");
        start = 1'b0;
        applyStimulus("lim0_term");
        checkOutput("lim0_done", 32'(done), 32'd1);
        applyStimulus("lim0_hold");

        // limit 7: full range with no wrap
        limit = 3'd7; start = 1'b1;
        applyStimulus("lim7_start");
        start = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus("lim7_run");
        checkOutput("lim7_top", 32'(count), 32'd7);
        applyStimulus("lim7_term");
        applyStimulus("lim7_hold");
        checkOutput("lim7_no_wrap", 32'(count), 32'd7);

        // Asynchronous reset between edges mid-run
        limit = 3'd5; start = 1'b1;
        applyStimulus("rstmid_start");
        start = 1'b0;
        applyStimulus("rstmid_run");
        applyStimulus("rstmid_run");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst.count", 32'(count), 32'd0);
        checkOutput("async_rst.state", 32'(state), 32'd0);
        checkOutput("async_rst.busy",  32'(busy),  32'd0);
        checkOutput("async_rst.done",  32'(done),  32'd0);
        applyStimulus("rstmid_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("rstmid_idle");
        limit = 3'd2; start = 1'b1;
        applyStimulus("restart");
        start = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("restart_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tff_count_sequencer.md
TFF_COUNT_SEQUENCER -- requirements
Module: tff_count_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning the counter width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-004 The block SHALL have port start, input, 1, a run request sampled on the clk edge.
REQ-005 The block SHALL have port stop, input, 1, an abort request sampled on the clk edge.
REQ-006 The block SHALL have port pause, input, 1, a level that freezes counting while high.
REQ-007 The block SHALL have port dir, input, 1, count direction: 0 = up, 1 = down; sampled only on an accepted start.
REQ-008 The block SHALL have port auto_reload, input, 1, a repeat-mode select sampled only on an accepted start.
REQ-009 The block SHALL have port limit, input, WIDTH, the terminal value sampled only on an accepted start.
REQ-010 The block SHALL have port count, output, WIDTH, the current counter value.
REQ-011 The block SHALL have port busy, output, 1, high in RUN and PAUSE.
REQ-012 The block SHALL have port done, output, 1, a registered one-cycle terminal-count pulse.
REQ-013 The block SHALL have port state, output, 2, the FSM state code.

Function
REQ-014 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2 and DONE=3.
REQ-015 Counter bits SHALL be toggle stages: bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down); bit 0 toggles every RUN cycle; no adder.
REQ-016 Input priority SHALL be stop > start > pause.
REQ-017 In any state, stop SHALL cause the next state to be IDLE, with count = 0 and done = 0.
REQ-018 In IDLE or DONE, start SHALL latch dir, limit and auto_reload and cause the next state to be RUN, with count = 0 (up) or the latched limit (down).
REQ-019 start SHALL be ignored in RUN and PAUSE.
REQ-020 Terminal value: latched limit when up; 0 when down.
REQ-021 In RUN with count != terminal and pause low, count SHALL step by 1 per cycle.
REQ-022 In RUN with count == terminal and auto_reload = 0, the next state SHALL be DONE, count SHALL hold, and done = 1 for the following cycle.
REQ-023 In RUN with count == terminal and auto_reload = 1, the state SHALL remain RUN, count SHALL reload the start value, and done = 1 for the following cycle.
REQ-024 In RUN with pause high and count != terminal, the next state SHALL be PAUSE and count SHALL hold.
REQ-025 Terminal detection SHALL take precedence over pause.
REQ-026 In PAUSE, count SHALL hold, and the block SHALL return to RUN on the edge where pause is sampled low.
REQ-027 A start with limit = 0 SHALL produce one RUN cycle at count 0, then done.
REQ-028 Counting SHALL never wrap; count SHALL stay within 0..latched limit.
REQ-029 In DONE, count SHALL hold until start or stop; pause SHALL be ignored in IDLE and DONE.

Reset
REQ-030 While rst is high, the block SHALL force state = IDLE, count = 0, busy = 0, done = 0, and latched dir/limit/auto_reload = 0, independent of clk.
REQ-031 Deassertion of rst SHALL NOT start counting; a start is required.
REQ-032 A rst assertion mid-run SHALL abort the run with no done pulse.

Structure
REQ-033 Package tff_seq_pkg SHALL hold the state encoding constants and the DIR_UP/DIR_DOWN constants.
REQ-034 Each counter bit SHALL be an instance of sub-module tff_stage (inputs clk, rst, t; output q; asynchronous reset to 0), instantiated WIDTH times.
REQ-035 All stages SHALL share clk; ripple clocking SHALL NOT be used.

Verification
REQ-036 Up count: WIDTH=3, dir=0, limit=5, auto_reload=0, start -> count 0,1,2,3,4,5, then done one cycle, state=DONE, count holds 5.
REQ-037 Down with reload: dir=1, limit=3, auto_reload=1 -> count 3,2,1,0,3,2,..., with done after every 0.
REQ-038 Pause: pause high for 3 cycles at count=2 -> count holds 2 in PAUSE, then resumes 3,4.
REQ-039 Abort: stop at count=4 while start is also high -> IDLE, count=0, no done.
REQ-040 Boundaries: limit=0 -> done after one RUN cycle; limit=7 up -> reaches 7 with no wrap to 0.
REQ-041 Reset: rst asserted mid-run between clk edges -> outputs cleared immediately; no counting after release until start.
